// File: rtl/cyclic_state_sequencer_pkg.sv
// Shared types and sizing helpers for the cyclic state sequencer
// and the timed FSMs built around it.
package seq_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cyclic_state_sequencer_dwell.sv
// Dwell counter: asserts done on the enabled cycle that completes
// DWELL enabled cycles; restart zeroes the count and suppresses done.
module seq_dwell_counter
  import seq_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic done
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign done   = en & ~restart & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cyclic_state_sequencer.sv
// Ring sequencer over NUM_STATES encodings with per-state dwell, up/down
// stepping, synchronous load, wrap pulse and sticky illegal-state fault.
module cyclic_state_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STATES = 3,
  parameter int DWELL      = 1,
  parameter int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [STATE_W-1:0] load_val,
  input  logic               clr_fault,
  output logic [STATE_W-1:0] state_out,
  output logic               wrap,
  output logic               fault
);

  // Compare against the top legal code so a power-of-2 NUM_STATES never
  // needs a constant wider than STATE_W.
  localparam logic [STATE_W-1:0] LAST_ST = STATE_W'(NUM_STATES - 1);

  logic [STATE_W-1:0] r_state;
  logic               r_wrap;
  logic               r_fault;

  logic [STATE_W-1:0] w_state_nxt;
  logic               w_wrap_nxt;
  logic               w_fault_set;
  logic               w_illegal;
  logic               w_load_bad;
  logic               w_restart;
  logic               w_step;
  dir_e               w_dir;

  assign w_illegal  = (r_state > LAST_ST);
  assign w_load_bad = (load_val > LAST_ST);
  assign w_restart  = w_illegal | load;
  assign w_dir      = dir_e'(dir);

  seq_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .restart (w_restart),
    .done    (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    w_fault_set = 1'b0;
    if (w_illegal) begin
      w_state_nxt = '0;
      w_fault_set = 1'b1;
    end else if (load) begin
      if (w_load_bad) begin
        w_state_nxt = '0;
        w_fault_set = 1'b1;
      end else begin
        w_state_nxt = load_val;
      end
    end else if (w_step) begin
      if (w_dir == DIR_UP) begin
        if (r_state == LAST_ST) begin
          w_state_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = r_state + 1'b1;
        end
      end else begin
        if (r_state == '0) begin
          w_state_nxt = LAST_ST;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = r_state - 1'b1;
        end
      end
    end
  end

  // A new fault outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_wrap  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (clr_fault) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign state_out = r_state;
  assign wrap      = r_wrap;
  assign fault     = r_fault;

endmodule

// File: tb/tb_cyclic_state_sequencer.sv
// Drives a 3-state/DWELL=1 and a 5-state/DWELL=3 sequencer with directed
// and random stimulus, checking every cycle against an integer ring model.
module tb_cyclic_state_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n3, en3, dir3, load3, clr3;
  logic [1:0] lv3, so3;
  logic       wrap3, fault3;

  logic       rst_n5, en5, dir5, load5, clr5;
  logic [2:0] lv5, so5;
  logic       wrap5, fault5;

  cyclic_state_sequencer #(.NUM_STATES(3), .DWELL(1)) u3 (
    .clk(clk), .rst_n(rst_n3), .en(en3), .dir(dir3), .load(load3),
    .load_val(lv3), .clr_fault(clr3), .state_out(so3), .wrap(wrap3), .fault(fault3)
  );

  cyclic_state_sequencer #(.NUM_STATES(5), .DWELL(3)) u5 (
    .clk(clk), .rst_n(rst_n5), .en(en5), .dir(dir5), .load(load5),
    .load_val(lv5), .clr_fault(clr5), .state_out(so5), .wrap(wrap5), .fault(fault5)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int NS[2] = '{3, 5};
  int DW[2] = '{1, 3};
  int ms[2], md[2], mf[2], mw[2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    ms[k] = 0; md[k] = 0; mf[k] = 0; mw[k] = 0;
  endtask

  // Ring semantics from the rules: out-of-range recovers, load, advance, hold.
  task automatic model_step(input int k, input bit en, input bit dir,
                            input bit load, input int lv, input bit clr);
    bit set_f;
    set_f = 0;
    mw[k] = 0;
    if (ms[k] >= NS[k]) begin
      ms[k] = 0; md[k] = 0; set_f = 1;
    end else if (load) begin
      md[k] = 0;
      if (lv < NS[k]) ms[k] = lv;
      else begin ms[k] = 0; set_f = 1; end
    end else if (en) begin
      if (md[k] == DW[k] - 1) begin
        md[k] = 0;
        if (!dir) begin
          mw[k] = (ms[k] == NS[k] - 1);
          ms[k] = (ms[k] + 1) % NS[k];
        end else begin
          mw[k] = (ms[k] == 0);
          ms[k] = (ms[k] + NS[k] - 1) % NS[k];
        end
      end else begin
        md[k]++;
      end
    end
    if (set_f) mf[k] = 1;
    else if (clr) mf[k] = 0;
  endtask

  task automatic compare();
    chk("n3.state", so3, ms[0]);
    chk("n3.wrap", wrap3, mw[0]);
    chk("n3.fault", fault3, mf[0]);
    chk("n5.state", so5, ms[1]);
    chk("n5.wrap", wrap5, mw[1]);
    chk("n5.fault", fault5, mf[1]);
  endtask

  task automatic cycle();
    model_step(0, en3, dir3, load3, int'(lv3), clr3);
    model_step(1, en5, dir5, load5, int'(lv5), clr5);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    int e3[4];
    int e5[8];
    e3 = '{1, 2, 0, 1};
    e5 = '{0, 0, 4, 4, 4, 3, 3, 3};

    rst_n3 = 0; en3 = 0; dir3 = 0; load3 = 0; clr3 = 0; lv3 = '0;
    rst_n5 = 0; en5 = 0; dir5 = 0; load5 = 0; clr5 = 0; lv5 = '0;
    model_reset(0);
    model_reset(1);
    #12;
    compare();
    @(negedge clk);
    rst_n3 = 1;
    rst_n5 = 1;

    // Free-running up on n3, down with dwell on n5.
    en3 = 1; dir3 = 0;
    en5 = 1; dir5 = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 4) begin
        chk("n3.seq", so3, e3[i]);
        chk("n3.seqwrap", wrap3, (e3[i] == 0) ? 1 : 0);
      end
      chk("n5.seq", so5, e5[i]);
      chk("n5.seqwrap", wrap5, (i == 2) ? 1 : 0);
    end

    // Freeze mid-dwell on n5.
    cycle();
    cycle();
    en5 = 0;
    cycle();
    cycle();
    chk("n5.frozen", so5, 2);
    en5 = 1;
    cycle();
    chk("n5.resume_hold", so5, 2);
    cycle();
    chk("n5.resume_step", so5, 1);

    // Load mid-dwell restarts dwell.
    cycle();
    load5 = 1; lv5 = 3'd3;
    cycle();
    chk("n5.load", so5, 3);
    load5 = 0;
    cycle();
    chk("n5.load_d1", so5, 3);
    cycle();
    chk("n5.load_d2", so5, 3);
    cycle();
    chk("n5.load_step", so5, 2);

    // Illegal load, clear, then set and clear together.
    load5 = 1; lv5 = 3'd6;
    cycle();
    chk("n5.badload_state", so5, 0);
    chk("n5.badload_fault", fault5, 1);
    load5 = 0; en5 = 0; clr5 = 1;
    cycle();
    chk("n5.clr", fault5, 0);
    load5 = 1; lv5 = 3'd7;
    cycle();
    chk("n5.set_wins", fault5, 1);
    load5 = 0; clr5 = 0;
    cycle();

    // Upset n3 into the unused encoding.
    en3 = 0; load3 = 0;
    force u3.r_state = 2'd3;
    #1;
    release u3.r_state;
    ms[0] = 3;
    #1;
    chk("n3.upset_seen", so3, 3);
    cycle();
    chk("n3.recover_state", so3, 0);
    chk("n3.recover_fault", fault3, 1);
    clr3 = 1;
    cycle();
    clr3 = 0;

    for (int i = 0; i < 300; i++) begin
      en3 = ($urandom_range(0, 3) != 0); dir3 = $urandom_range(0, 1);
      load3 = ($urandom_range(0, 15) == 0); lv3 = 2'($urandom_range(0, 3));
      clr3 = ($urandom_range(0, 7) == 0);
      en5 = ($urandom_range(0, 3) != 0); dir5 = $urandom_range(0, 1);
      load5 = ($urandom_range(0, 15) == 0); lv5 = 3'($urandom_range(0, 7));
      clr5 = ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Asynchronous reset of n3 while sitting in state 2.
    en3 = 0; dir3 = 0; load3 = 1; lv3 = 2'd2; clr3 = 0;
    en5 = 0; load5 = 0; clr5 = 0;
    cycle();
    load3 = 0;
    chk("n3.pre_rst", so3, 2);
    #2;
    rst_n3 = 0;
    model_reset(0);
    #1;
    chk("n3.async_state", so3, 0);
    chk("n3.async_wrap", wrap3, 0);
    chk("n3.async_fault", fault3, 0);
    @(negedge clk);
    rst_n3 = 1;
    en3 = 1;
    cycle();
    chk("n3.post_rst", so3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
